// File: rtl/mem_arbiter_ctrl.sv
// Memory arbiter: shares base/ext SRAM and UART between the fetch and load/store ports.
// Decodes the address map and sequences registered SRAM/UART strobes.
module mem_arbiter_ctrl #(
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 1,
    parameter int UART_PULSE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be_n,
    output logic        mem_ack,
    output logic        mem_err,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    output logic [31:0] base_ram_wdata,
    output logic        base_ram_wdata_oe,
    input  logic [31:0] base_ram_rdata,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n,
    output logic [31:0] ext_ram_wdata,
    output logic        ext_ram_wdata_oe,
    input  logic [31:0] ext_ram_rdata,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre,
    output logic [3:0]  ram_be_n,
    output logic [1:0]  mem_use,
    output logic [7:0]  uart_rd,
    output logic [31:0] data_base_out,
    output logic [31:0] data_ext_out
);

    typedef enum logic [2:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, U_RD, U_WR, DONE
    } state_t;

    typedef enum logic [2:0] {R_BASE, R_EXT, R_UDATA, R_USTAT, R_NONE} region_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [3:0]  be_n;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic [31:0] wdata;
        logic        wdata_oe;
    } sram_t;

    localparam sram_t SRAM_RST = '{addr: '0, be_n: '0, ce_n: 1'b1, oe_n: 1'b1,
                                   we_n: 1'b1, wdata: '0, wdata_oe: 1'b0};

    function automatic region_t decode(input logic [31:0] a);
        region_t r;
        unique case (1'b1)
            a[31:22] == 10'h200: r = R_BASE;
            a[31:22] == 10'h201: r = R_EXT;
            a == 32'h1000_0000:  r = R_UDATA;
            a == 32'h1000_0005:  r = R_USTAT;
            default:             r = R_NONE;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fetch_q, fetch_d;
    logic        sel_ext_q, sel_ext_d;
    logic        stat_q, stat_d;
    logic        err_q, err_d;
    sram_t       base_q, base_d, ext_q, ext_d;
    logic        if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic        mem_ack_q, mem_ack_d, mem_err_q, mem_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        uart_rdn_q, uart_rdn_d, uart_wrn_q, uart_wrn_d;
    logic [3:0]  ram_be_n_q, ram_be_n_d;
    logic [1:0]  mem_use_q, mem_use_d;
    logic [7:0]  uart_rd_q, uart_rd_d;
    logic [31:0] data_base_q, data_base_d, data_ext_q, data_ext_d;

    logic [31:0] req_addr;
    region_t     region;
    logic        is_sram, is_ld, sel, upd, done, derr;
    sram_t       cur;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fetch_d     = fetch_q;
        sel_ext_d   = sel_ext_q;
        stat_d      = stat_q;
        err_d       = err_q;
        base_d      = base_q;
        ext_d       = ext_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        mem_ack_d   = 1'b0;
        mem_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        uart_rdn_d  = uart_rdn_q;
        uart_wrn_d  = uart_wrn_q;
        ram_be_n_d  = ram_be_n_q;
        mem_use_d   = mem_use_q;
        uart_rd_d   = uart_rd_q;
        data_base_d = data_base_q;
        data_ext_d  = data_ext_q;
        req_addr    = mem_req ? mem_addr : if_addr;
        region      = decode(req_addr);
        is_sram     = (region == R_BASE) || (region == R_EXT);
        is_ld       = !mem_req || !mem_we;
        sel         = (state_q == IDLE) ? (region == R_EXT) : sel_ext_q;
        cur         = sel ? ext_q : base_q;
        upd         = 1'b0;
        done        = 1'b0;
        derr        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((mem_req || if_req) && !if_ack_q && !mem_ack_q) begin
                    fetch_d   = !mem_req;
                    sel_ext_d = (region == R_EXT);
                    stat_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = DONE;
                    if (mem_req && !mem_we && region != R_NONE) begin
                        ram_be_n_d = mem_be_n;
                        mem_use_d  = (region == R_BASE) ? 2'b00 :
                                     (region == R_EXT)  ? 2'b01 : 2'b10;
                    end
                    unique case (1'b1)
                        is_sram && is_ld: begin
                            cur.addr = req_addr[21:2];
                            cur.be_n = 4'b0000;
                            cur.ce_n = 1'b0;
                            cur.oe_n = 1'b0;
                            upd      = 1'b1;
                            cnt_d    = 8'(RD_WAIT);
                            state_d  = RD;
                        end
                        is_sram && !is_ld: begin
                            cur.addr     = req_addr[21:2];
                            cur.be_n     = mem_be_n;
                            cur.ce_n     = 1'b0;
                            cur.wdata    = mem_wdata;
                            cur.wdata_oe = 1'b1;
                            upd          = 1'b1;
                            state_d      = WR_SETUP;
                        end
                        mem_req && region == R_UDATA && is_ld: begin
                            uart_rdn_d = 1'b0;
                            cnt_d      = 8'(UART_PULSE - 1);
                            state_d    = U_RD;
                        end
                        mem_req && region == R_UDATA && !is_ld: begin
                            cur.wdata    = {24'h0, mem_wdata[7:0]};
                            cur.wdata_oe = 1'b1;
                            upd          = 1'b1;
                            uart_wrn_d   = 1'b0;
                            cnt_d        = 8'(UART_PULSE - 1);
                            state_d      = U_WR;
                        end
                        mem_req && region == R_USTAT && is_ld: stat_d = 1'b1;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            RD: begin
                if (cnt_q == 8'd0) begin
                    cur.ce_n = 1'b1;
                    cur.oe_n = 1'b1;
                    upd      = 1'b1;
                    done     = 1'b1;
                    state_d  = IDLE;
                    if (fetch_q)
                        if_rdata_d = sel ? ext_ram_rdata : base_ram_rdata;
                    else if (sel)
                        data_ext_d = ext_ram_rdata;
                    else
                        data_base_d = base_ram_rdata;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_SETUP: begin
                cur.we_n = 1'b0;
                upd      = 1'b1;
                cnt_d    = 8'(WR_WAIT - 1);
                state_d  = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 8'd0) begin
                    cur.we_n = 1'b1;
                    upd      = 1'b1;
                    state_d  = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_HOLD: begin
                cur.ce_n     = 1'b1;
                cur.wdata_oe = 1'b0;
                upd          = 1'b1;
                done         = 1'b1;
                state_d      = IDLE;
            end
            U_RD: begin
                if (cnt_q == 8'd0) begin
                    uart_rd_d  = base_ram_rdata[7:0];
                    uart_rdn_d = 1'b1;
                    done       = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            U_WR: begin
                if (cnt_q == 8'd0) begin
                    uart_wrn_d   = 1'b1;
                    cur.wdata_oe = 1'b0;
                    upd          = 1'b1;
                    done         = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                derr    = err_q;
                state_d = IDLE;
                if (stat_q)
                    uart_rd_d = {2'b00, uart_tbre & uart_tsre, 4'b0000, uart_dataready};
            end
        endcase

        if (upd) begin
            if (sel) ext_d = cur;
            else     base_d = cur;
        end
        if (done) begin
            if (fetch_q) begin
                if_ack_d = 1'b1;
                if_err_d = derr;
            end else begin
                mem_ack_d = 1'b1;
                mem_err_d = derr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fetch_q     <= 1'b0;
            sel_ext_q   <= 1'b0;
            stat_q      <= 1'b0;
            err_q       <= 1'b0;
            base_q      <= SRAM_RST;
            ext_q       <= SRAM_RST;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            uart_rdn_q  <= 1'b1;
            uart_wrn_q  <= 1'b1;
            ram_be_n_q  <= '0;
            mem_use_q   <= '0;
            uart_rd_q   <= '0;
            data_base_q <= '0;
            data_ext_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fetch_q     <= fetch_d;
            sel_ext_q   <= sel_ext_d;
            stat_q      <= stat_d;
            err_q       <= err_d;
            base_q      <= base_d;
            ext_q       <= ext_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            mem_ack_q   <= mem_ack_d;
            mem_err_q   <= mem_err_d;
            if_rdata_q  <= if_rdata_d;
            uart_rdn_q  <= uart_rdn_d;
            uart_wrn_q  <= uart_wrn_d;
            ram_be_n_q  <= ram_be_n_d;
            mem_use_q   <= mem_use_d;
            uart_rd_q   <= uart_rd_d;
            data_base_q <= data_base_d;
            data_ext_q  <= data_ext_d;
        end
    end

    assign if_rdata          = if_rdata_q;
    assign if_ack            = if_ack_q;
    assign if_err            = if_err_q;
    assign mem_ack           = mem_ack_q;
    assign mem_err           = mem_err_q;
    assign base_ram_addr     = base_q.addr;
    assign base_ram_be_n     = base_q.be_n;
    assign base_ram_ce_n     = base_q.ce_n;
    assign base_ram_oe_n     = base_q.oe_n;
    assign base_ram_we_n     = base_q.we_n;
    assign base_ram_wdata    = base_q.wdata;
    assign base_ram_wdata_oe = base_q.wdata_oe;
    assign ext_ram_addr      = ext_q.addr;
    assign ext_ram_be_n      = ext_q.be_n;
    assign ext_ram_ce_n      = ext_q.ce_n;
    assign ext_ram_oe_n      = ext_q.oe_n;
    assign ext_ram_we_n      = ext_q.we_n;
    assign ext_ram_wdata     = ext_q.wdata;
    assign ext_ram_wdata_oe  = ext_q.wdata_oe;
    assign uart_rdn          = uart_rdn_q;
    assign uart_wrn          = uart_wrn_q;
    assign ram_be_n          = ram_be_n_q;
    assign mem_use           = mem_use_q;
    assign uart_rd           = uart_rd_q;
    assign data_base_out     = data_base_q;
    assign data_ext_out      = data_ext_q;

endmodule
